// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - three-phase sequencer driving an external ALU over a four-entry register file
// Optional zero_flag output is enabled by defining ALU_SEQUENCER_ZERO_FLAG_EN.
module alu_sequencer #(
  parameter int WORD_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] instr_op,
  input  logic [1:0]              instr_dst,
  input  logic [1:0]              instr_srca,
  input  logic [1:0]              instr_srcb,
  input  logic                    ld_en,
  input  logic [1:0]              ld_addr,
  input  logic [WORD_WIDTH-1:0]   ld_data,
  input  logic [1:0]              rd_addr,
  output logic [WORD_WIDTH-1:0]   rd_data,
  output logic [WORD_WIDTH-1:0]   alu_operand1,
  output logic [WORD_WIDTH-1:0]   alu_operand2,
  output logic [OPCODE_WIDTH-1:0] alu_opCode,
  input  logic [WORD_WIDTH-1:0]   alu_result,
  input  logic                    alu_carryOut,
  output logic                    wb_valid,
  output logic [WORD_WIDTH-1:0]   wb_data,
  output logic                    carry_flag
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
  ,
  output logic                    zero_flag
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [1:0]              dst_q, srca_q, srcb_q;
  logic [WORD_WIDTH-1:0]   res_q;
  logic                    cy_q;
  logic                    carry_flag_q;
  logic [WORD_WIDTH-1:0]   regs_q [4];
  logic                    accept;

  assign accept = instr_valid && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dst_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= instr_op;
        dst_q  <= instr_dst;
        srca_q <= instr_srca;
        srcb_q <= instr_srcb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      cy_q  <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_q <= alu_result;
      cy_q  <= alu_carryOut;
    end
  end

  // The writeback assignment comes last so it overrides a direct load to the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      carry_flag_q <= 1'b0;
    end else begin
      if (ld_en) regs_q[ld_addr] <= ld_data;
      if (state_q == S_WB) begin
        regs_q[dst_q] <= res_q;
        carry_flag_q  <= cy_q;
      end
    end
  end

`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
  logic zero_flag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_flag_q <= 1'b0;
    end else if (state_q == S_WB) begin
      zero_flag_q <= (res_q == '0);
    end
  end

  assign zero_flag = zero_flag_q;
`endif

  assign instr_ready  = (state_q == S_IDLE) && !reset;
  assign wb_valid     = (state_q == S_WB) && !reset;
  assign wb_data      = reset ? '0 : res_q;
  assign carry_flag   = carry_flag_q;
  assign rd_data      = regs_q[rd_addr];
  assign alu_operand1 = regs_q[srca_q];
  assign alu_operand2 = regs_q[srcb_q];
  assign alu_opCode   = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer acting as its external ALU
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_dst, instr_srca, instr_srcb;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] alu_operand1, alu_operand2;
  logic [3:0] alu_opCode;
  logic [7:0] alu_result;
  logic       alu_carryOut;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic       carry_flag;
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  alu_sequencer #(.WORD_WIDTH(8), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_dst(instr_dst), .instr_srca(instr_srca), .instr_srcb(instr_srcb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_opCode(alu_opCode),
    .alu_result(alu_result), .alu_carryOut(alu_carryOut),
    .wb_valid(wb_valid), .wb_data(wb_data), .carry_flag(carry_flag)
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
    , .zero_flag(zero_flag)
`endif
  );

  always #5 clk = ~clk;

  // Returns {carry, result}; subtracts report borrow in the carry bit.
  function automatic logic [8:0] alu_f(logic [3:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, ~a};
      4'd6:    return {a, 1'b0};
      4'd7:    return {a[0], 1'b0, a[7:1]};
      4'd8:    return {1'b0, a} + 9'd1;
      4'd9:    return {1'b0, a} - 9'd1;
      4'd10:   return {1'b0, a};
      4'd11:   return {1'b0, b};
      4'd12:   return {1'b0, ~(a & b)};
      4'd13:   return {1'b0, ~(a | b)};
      4'd14:   return {1'b0, ~(a ^ b)};
      default: return {1'b0, a} + {1'b0, b} + 9'd1;
    endcase
  endfunction

  assign {alu_carryOut, alu_result} = alu_f(alu_opCode, alu_operand1, alu_operand2);

  typedef struct {
    logic [7:0] d;
    logic       c;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl [4];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every wb_valid, then checks flags and pulse width one cycle later.
  logic       pend = 1'b0;
  exp_t       pend_e;
  int         last_wb = -100;
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("carry_flag", carry_flag, pend_e.c);
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
        chk("zero_flag", zero_flag, pend_e.d == 8'h00);
`endif
        chk("wb_pulse_width", wb_valid, 1'b0);
        pend = 1'b0;
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          pend_e = exp_q.pop_front();
          chk("wb_data", wb_data, pend_e.d);
          chk("wb_spacing_ge3", (cyc - last_wb) >= 3, 1);
          last_wb = cyc;
          pend = 1'b1;
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic ld(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    rd_addr = idx;
    #1;
    chk(name, rd_data, exp);
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge of the EXEC cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] a,
                       input logic [1:0] b, input logic use_c, input logic [7:0] cd,
                       input logic cc);
    logic [8:0] r;
    int n = 0;
    instr_valid = 1'b1; instr_op = op; instr_dst = dst; instr_srca = a; instr_srcb = b;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    r = alu_f(op, mdl[a], mdl[b]);
    if (use_c) push_exp(cd, cc);
    else       push_exp(r[7:0], r[8]);
    mdl[dst] = use_c ? cd : r[7:0];
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ready_exec", instr_ready, 1'b0);
  endtask

  task automatic finish_instr;
    @(negedge clk);
    chk("ready_wb", instr_ready, 1'b0);
    @(negedge clk);
    chk("ready_idle", instr_ready, 1'b1);
  endtask

  logic [7:0] pa [4];
  logic [7:0] pb [4];

  initial begin
    int acc;
    int n;
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_dst = '0; instr_srca = '0;
    instr_srcb = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    pa[0] = 8'h00; pb[0] = 8'h00;
    pa[1] = 8'hA5; pb[1] = 8'h5A;
    pa[2] = 8'hFF; pb[2] = 8'h80;
    pa[3] = 8'h37; pb[3] = 8'hC9;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 8'h00);
    chk("rst_carry", carry_flag, 1'b0);
`ifdef ALU_SEQUENCER_ZERO_FLAG_EN
    chk("rst_zero", zero_flag, 1'b0);
`endif
    chk("rst_r0", rd_data, 8'h00);
    reset = 1'b0;
    #1 chk("post_rst_ready", instr_ready, 1'b1);
    @(negedge clk);

    // Reset during EXEC discards the in-flight instruction.
    ld(2'd0, 8'h05);
    ld(2'd1, 8'h03);
    instr_valid = 1'b1; instr_op = 4'd0; instr_dst = 2'd2; instr_srca = 2'd0; instr_srcb = 2'd1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("exec_ready_low", instr_ready, 1'b0);
    reset = 1'b1;
    #1 chk("midrst_ready", instr_ready, 1'b0);
    chk("midrst_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    #1 chk("midrst_release_ready", instr_ready, 1'b1);
    chk_reg("midrst_r2", 2'd2, 8'h00);
    chk_reg("midrst_r0", 2'd0, 8'h00);

    // 5 + 3 = 8 into r2.
    ld(2'd0, 8'h05);
    ld(2'd1, 8'h03);
    issue(4'd0, 2'd2, 2'd0, 2'd1, 1'b1, 8'h08, 1'b0);
    finish_instr();
    chk_reg("add_r2", 2'd2, 8'h08);

    // FF + 01 wraps to 00 with carry into r3.
    ld(2'd0, 8'hFF);
    ld(2'd1, 8'h01);
    issue(4'd0, 2'd3, 2'd0, 2'd1, 1'b1, 8'h00, 1'b1);
    finish_instr();
    chk_reg("carry_r3", 2'd3, 8'h00);

    // Valid held high: r0 += r1 three times in nine cycles.
    ld(2'd0, 8'h01);
    ld(2'd1, 8'h02);
    acc = 0;
    instr_valid = 1'b1; instr_op = 4'd0; instr_dst = 2'd0; instr_srca = 2'd0; instr_srcb = 2'd1;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) begin
        push_exp(mdl[0] + mdl[1], 1'b0);
        mdl[0] = mdl[0] + mdl[1];
        acc++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("cont_accepts", acc, 3);
    chk_reg("cont_r0", 2'd0, 8'h07);

    // Load and writeback hit r2 on the same edge: writeback wins.
    ld(2'd0, 8'h10);
    ld(2'd1, 8'h20);
    issue(4'd0, 2'd2, 2'd0, 2'd1, 1'b1, 8'h30, 1'b0);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
    @(negedge clk);
    ld_en = 1'b0;
    chk_reg("wb_beats_ld_r2", 2'd2, 8'h30);

    // Load to a source during EXEC does not affect the operand already presented.
    ld(2'd0, 8'h40);
    ld(2'd1, 8'h01);
    issue(4'd1, 2'd3, 2'd0, 2'd1, 1'b1, 8'h3F, 1'b0);
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h99;
    @(negedge clk);
    ld_en = 1'b0;
    mdl[0] = 8'h99;
    @(negedge clk);
    chk_reg("exec_ld_r3", 2'd3, 8'h3F);
    chk_reg("exec_ld_r0", 2'd0, 8'h99);

    // srca == srcb == dst.
    ld(2'd3, 8'h81);
    issue(4'd0, 2'd3, 2'd3, 2'd3, 1'b1, 8'h02, 1'b1);
    finish_instr();
    chk_reg("self_r3", 2'd3, 8'h02);

    for (int op = 0; op < 16; op++) begin
      for (int p = 0; p < 4; p++) begin
        ld(2'd0, pa[p]);
        ld(2'd1, pb[p]);
        issue(op[3:0], 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0);
        finish_instr();
      end
      chk_reg("sweep_r2", 2'd2, mdl[2]);
    end

    n = 0;
    while ((exp_q.size() != 0 || pend) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
